// File: rtl/fp_sig_addnorm_pkg.sv
// Shared FP32 definitions for the vector unit adder datapath:
// field widths, special patterns and result/flag bundles.
package fp_sig_addnorm_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_SIG_W  = FP_FRAC_W + 1;
    localparam int FP_BIAS   = 127;
    localparam int EXP_MAX   = 255;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    localparam fp32_t FP32_ZERO = '{sign: 1'b0, exp: 8'h00, frac: 23'h0};
    localparam fp32_t FP32_INF  = '{sign: 1'b0, exp: 8'hFF, frac: 23'h0};

endpackage

// File: rtl/fp_sig_addnorm_lzc.sv
// Combinational 28-bit leading-zero counter with all-zero flag.
module fp_lzc28 (
    input  logic [27:0] value,
    output logic [4:0]  count,
    output logic        zero
);

    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (value[i]) begin
                count = 5'(27 - i);
            end
        end
    end

    assign zero = ~|value;

endmodule

// File: rtl/fp_sig_addnorm.sv
// FP32 significand add/subtract, normalise and RNE round.
// Two register stages with valid/ready on both sides.
module fp_sig_addnorm
    import fp_sig_addnorm_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int SIG_W = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   sign_l_i,
    input  logic                   sign_s_i,
    input  logic [EXP_W-1:0]       exp_i,
    input  logic [SIG_W-1:0]       sig_l_i,
    input  logic [SIG_W-1:0]       sig_s_i,
    input  logic [2:0]             guard_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [EXP_W+SIG_W-1:0] result_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    output logic                   inexact_o
);

    localparam int SUM_W = SIG_W + 4;
    localparam int XE_W  = EXP_W + 2;

    logic             s1_valid;
    logic [SUM_W-1:0] s1_sum;
    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;

    logic advance;
    logic accept;

    assign advance = !valid_o || ready_i;
    assign ready_o = !s1_valid || advance;
    assign accept  = valid_i && ready_o;

    logic             eff_sub;
    logic [SUM_W-1:0] ext_l;
    logic [SUM_W-1:0] ext_s;
    logic [SUM_W-1:0] sum_d;

    assign eff_sub = sign_l_i ^ sign_s_i;
    assign ext_l   = {1'b0, sig_l_i, 3'b000};
    assign ext_s   = {1'b0, sig_s_i, guard_i};
    assign sum_d   = eff_sub ? ext_l - ext_s : ext_l + ext_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
        end else begin
            if (ready_o) begin
                s1_valid <= valid_i;
            end
            if (accept) begin
                s1_sum  <= sum_d;
                s1_sign <= sign_l_i;
                s1_exp  <= exp_i;
            end
        end
    end

    logic [4:0]       lzc_cnt;
    logic             lzc_zero;
    logic [4:0]       lz;
    logic [SUM_W-2:0] norm;
    logic [XE_W-1:0]  exp_n;
    logic [XE_W-1:0]  exp_r;
    logic [SIG_W:0]   rnd;
    logic [SIG_W-2:0] frac;
    logic             g_bit;
    logic             r_bit;
    logic             s_bit;
    logic             round_up;
    logic             lost;
    logic             exp_low;
    logic             exp_high;
    fp32_t            res_d;
    fp_flags_t        flg_d;

    fp_lzc28 u_lzc (
        .value (s1_sum),
        .count (lzc_cnt),
        .zero  (lzc_zero)
    );

    always_comb begin
        lz    = lzc_cnt - 5'd1;
        norm  = '0;
        exp_n = '0;
        // Carry out: the dropped LSB folds into sticky.
        if (s1_sum[SUM_W-1]) begin
            norm    = s1_sum[SUM_W-1:1];
            norm[0] = s1_sum[1] | s1_sum[0];
            exp_n   = {2'b00, s1_exp} + XE_W'(1);
        end else begin
            norm  = s1_sum[SUM_W-2:0] << lz;
            exp_n = {2'b00, s1_exp} - XE_W'(lz);
        end

        g_bit    = norm[2];
        r_bit    = norm[1];
        s_bit    = norm[0];
        round_up = g_bit & (r_bit | s_bit | norm[3]);
        lost     = g_bit | r_bit | s_bit;

        rnd   = {1'b0, norm[SUM_W-2:3]} + (SIG_W+1)'(round_up);
        frac  = rnd[SIG_W] ? rnd[SIG_W-1:1] : rnd[SIG_W-2:0];
        exp_r = rnd[SIG_W] ? exp_n + XE_W'(1) : exp_n;

        // Exponents are carried two bits wider; the MSB marks negative.
        exp_low  = exp_n[XE_W-1] || (exp_n == '0);
        exp_high = !exp_r[XE_W-1] && (exp_r >= XE_W'(EXP_MAX));

        res_d = '{sign: s1_sign, exp: exp_r[EXP_W-1:0], frac: frac};
        flg_d = '{overflow: 1'b0, underflow: 1'b0, inexact: lost};

        if (lzc_zero) begin
            res_d = FP32_ZERO;
            flg_d = '0;
        end else if (exp_low) begin
            res_d      = FP32_ZERO;
            res_d.sign = s1_sign;
            flg_d      = '{overflow: 1'b0, underflow: 1'b1, inexact: 1'b1};
        end else if (exp_high) begin
            res_d      = FP32_INF;
            res_d.sign = s1_sign;
            flg_d      = '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            result_o    <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else if (advance) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                result_o    <= res_d;
                overflow_o  <= flg_d.overflow;
                underflow_o <= flg_d.underflow;
                inexact_o   <= flg_d.inexact;
            end
        end
    end

endmodule
